regfile_bus_ctrl: RTL and testbench

Bus-side controller for the tri-state register file: the initiator that drives the per-register `store`, `enable_a` and `enable_b` strobes and the shared write-data bus. It samples the resolved A/B read buses. It accepts one register-file transaction at a time over a valid/ready request channel, and returns both operands over a valid/ready response channel. It sits between the decode/execute logic and the array of `register` instances.

---
 rtl/regbus_pkg.sv | 28 ++
 rtl/regfile_bus_ctrl_if.sv | 46 ++++
 rtl/regbus_decode.sv | 23 ++
 rtl/regfile_bus_ctrl.sv | 118 +++++++++++
 tb/tb_regfile_bus_ctrl.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/regbus_pkg.sv
// Shared types and defaults for the register-file bus controller.
package regbus_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int IDXW  = 5;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    RESP,
    WRITE
  } regbus_state_t;

  typedef struct packed {
    logic [IDXW-1:0] rs1;
    logic [IDXW-1:0] rs2;
    logic [IDXW-1:0] rd;
    logic            we;
    logic [XLEN-1:0] wdata;
  } regbus_req_t;

  // Register 0 is hardwired to zero and indices past the array have no register behind them.
  function automatic logic idx_in_range(int unsigned idx, int unsigned nregs);
    return (idx != 0) && (idx < nregs);
  endfunction

endpackage

// File: rtl/regfile_bus_ctrl_if.sv
// Request, response and register-bus signals of regfile_bus_ctrl.
// slave = controller view, master = requester / register-array view.
interface regfile_bus_ctrl_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int IDXW  = 5
);
  logic             req_valid;
  logic             req_ready;
  logic [IDXW-1:0]  req_rs1;
  logic [IDXW-1:0]  req_rs2;
  logic [IDXW-1:0]  req_rd;
  logic             req_we;
  logic [XLEN-1:0]  req_wdata;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [XLEN-1:0]  rsp_a;
  logic [XLEN-1:0]  rsp_b;

  logic [NREGS-1:0] enable_a;
  logic [NREGS-1:0] enable_b;
  logic [NREGS-1:0] store;
  logic [XLEN-1:0]  wr_data;
  logic [XLEN-1:0]  a_bus;
  logic [XLEN-1:0]  b_bus;

  modport slave (
    input  req_valid, req_rs1, req_rs2, req_rd, req_we, req_wdata,
    output req_ready,
    output rsp_valid, rsp_a, rsp_b,
    input  rsp_ready,
    output enable_a, enable_b, store, wr_data,
    input  a_bus, b_bus
  );

  modport master (
    output req_valid, req_rs1, req_rs2, req_rd, req_we, req_wdata,
    input  req_ready,
    input  rsp_valid, rsp_a, rsp_b,
    output rsp_ready,
    input  enable_a, enable_b, store, wr_data,
    output a_bus, b_bus
  );

endinterface

// File: rtl/regbus_decode.sv
// Gated register index to one-hot strobe decoder; never selects register 0
// or an index beyond the array.
module regbus_decode
  import regbus_pkg::*;
#(
  parameter int NREGS = regbus_pkg::NREGS,
  parameter int IDXW  = regbus_pkg::IDXW
) (
  input  logic [IDXW-1:0]  idx_i,
  input  logic             gate_i,
  output logic [NREGS-1:0] onehot_o
);

  // NOTE: the all-zero default ahead of the conditional keeps this purely
  // combinational; without it the partially assigned vector would infer a latch.
  always_comb begin
    onehot_o = '0;
    if (gate_i && idx_in_range(32'(idx_i), NREGS)) begin
      onehot_o[idx_i] = 1'b1;
    end
  end

endmodule

// File: rtl/regfile_bus_ctrl.sv
// Initiator for the tri-state register file: one transaction at a time, read then
// optional writeback. Define REGBUS_WRITE_FIRST_EN to perform the writeback before the read.
module regfile_bus_ctrl
  import regbus_pkg::*;
#(
  parameter int XLEN  = regbus_pkg::XLEN,
  parameter int NREGS = regbus_pkg::NREGS,
  parameter int IDXW  = regbus_pkg::IDXW
) (
  input  logic                clk,
  input  logic                reset_n,
  regfile_bus_ctrl_if.slave   bus
);

  regbus_state_t    state_q;
  regbus_req_t      req_q;
  logic             wr_done_q;
  logic [XLEN-1:0]  rsp_a_q;
  logic [XLEN-1:0]  rsp_b_q;
  logic [XLEN-1:0]  wr_data_q;

  logic [NREGS-1:0] en_a;
  logic [NREGS-1:0] en_b;
  logic [NREGS-1:0] store;
  logic             rd_ok;

  assign rd_ok = req_q.we && idx_in_range(32'(req_q.rd), NREGS);

  // Strobes come only from flops, so reset clears them without waiting for an edge.
  regbus_decode #(.NREGS(NREGS), .IDXW(IDXW)) u_dec_a (
    .idx_i    (req_q.rs1),
    .gate_i   (state_q == DRIVE),
    .onehot_o (en_a)
  );

  regbus_decode #(.NREGS(NREGS), .IDXW(IDXW)) u_dec_b (
    .idx_i    (req_q.rs2),
    .gate_i   (state_q == DRIVE),
    .onehot_o (en_b)
  );

  regbus_decode #(.NREGS(NREGS), .IDXW(IDXW)) u_dec_st (
    .idx_i    (req_q.rd),
    .gate_i   (state_q == WRITE),
    .onehot_o (store)
  );

  // NOTE: every register here updates with <= so all of them see the pre-edge
  // values of each other; blocking assignments would make the result order-dependent.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      req_q     <= '0;
      wr_done_q <= 1'b0;
      rsp_a_q   <= '0;
      rsp_b_q   <= '0;
      wr_data_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            req_q.rs1   <= bus.req_rs1;
            req_q.rs2   <= bus.req_rs2;
            req_q.rd    <= bus.req_rd;
            req_q.we    <= bus.req_we;
            req_q.wdata <= bus.req_wdata;
            wr_done_q   <= 1'b0;
`ifdef REGBUS_WRITE_FIRST_EN
            if (bus.req_we && idx_in_range(32'(bus.req_rd), NREGS)) begin
              wr_data_q <= bus.req_wdata;
              state_q   <= WRITE;
            end else begin
              state_q <= DRIVE;
            end
`else
            state_q <= DRIVE;
`endif
          end
        end
        DRIVE: begin
          // An undriven bus carries nothing meaningful, so unselected operands read as zero.
          rsp_a_q <= (|en_a) ? bus.a_bus : '0;
          rsp_b_q <= (|en_b) ? bus.b_bus : '0;
          state_q <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            if (rd_ok && !wr_done_q) begin
              wr_data_q <= req_q.wdata;
              state_q   <= WRITE;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        WRITE: begin
          wr_done_q <= 1'b1;
`ifdef REGBUS_WRITE_FIRST_EN
          state_q <= DRIVE;
`else
          state_q <= IDLE;
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_a     = rsp_a_q;
  assign bus.rsp_b     = rsp_b_q;
  assign bus.enable_a  = en_a;
  assign bus.enable_b  = en_b;
  assign bus.store     = store;
  assign bus.wr_data   = wr_data_q;

endmodule

// File: tb/tb_regfile_bus_ctrl.sv
// Bench for regfile_bus_ctrl: register-array bus model, transaction-level reference
// model with a per-cycle compare process, and directed literal checks.
module tb_regfile_bus_ctrl;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int IDXW  = 5;
  localparam logic [XLEN-1:0] FLOAT_PAT = 32'hBAD0_F00D;

  logic clk;
  logic reset_n;
  int   n_checks = 0;
  int   n_errors = 0;

  regfile_bus_ctrl_if #(.XLEN(XLEN), .NREGS(NREGS), .IDXW(IDXW)) bus ();

  regfile_bus_ctrl #(.XLEN(XLEN), .NREGS(NREGS), .IDXW(IDXW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register array on the bus; an undriven bus reads as junk rather than zero.
  logic [XLEN-1:0] mem [NREGS];
  logic [XLEN-1:0] a_val, b_val;

  always_comb begin
    a_val = FLOAT_PAT;
    b_val = ~FLOAT_PAT;
    for (int i = 0; i < NREGS; i++) begin
      if (bus.enable_a[i]) a_val = mem[i];
      if (bus.enable_b[i]) b_val = mem[i];
    end
  end
  assign bus.a_bus = a_val;
  assign bus.b_bus = b_val;

  always @(posedge clk) begin
    for (int i = 0; i < NREGS; i++) begin
      if (bus.store[i]) mem[i] <= bus.wr_data;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [NREGS-1:0] onehot(input int idx);
    logic [NREGS-1:0] v;
    v = '0;
    if (idx > 0 && idx < NREGS) v[idx] = 1'b1;
    return v;
  endfunction

  function automatic bit reg_ok(input int idx);
    return idx > 0 && idx < NREGS;
  endfunction

  // Reference model: architectural register contents plus the transaction in flight.
  logic [XLEN-1:0] ref_regs [NREGS];
  int              cur_rs1, cur_rs2, cur_rd;
  logic [XLEN-1:0] cur_wdata, cur_exp_a, cur_exp_b;
  int              en_a_cnt, en_b_cnt, st_cnt;
  logic [XLEN-1:0] last_a, last_b;

  // Compare process: every cycle, outputs must match what the current transaction allows.
  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.rsp_valid) begin
        check("rsp_a", bus.rsp_a, cur_exp_a);
        check("rsp_b", bus.rsp_b, cur_exp_b);
        check("strobes_in_resp", 32'(|{bus.enable_a, bus.enable_b, bus.store}), 32'd0);
      end
      if (bus.enable_a != '0) begin
        check("enable_a", bus.enable_a, onehot(cur_rs1));
        en_a_cnt++;
      end
      if (bus.enable_b != '0) begin
        check("enable_b", bus.enable_b, onehot(cur_rs2));
        en_b_cnt++;
      end
      if (bus.store != '0) begin
        check("store", bus.store, onehot(cur_rd));
        check("wr_data", bus.wr_data, cur_wdata);
        st_cnt++;
      end
      if (bus.rsp_valid || bus.enable_a != '0 || bus.enable_b != '0 || bus.store != '0)
        check("req_ready_busy", 32'(bus.req_ready), 32'd0);
    end
  end

  task automatic txn(input int rs1, input int rs2, input int rd, input bit we,
                     input logic [XLEN-1:0] wdata, input int stall);
    bit   wok, got, hs;
    int   lat, post, exp_lat, exp_post;
    logic [XLEN-1:0] held_a, held_b;

    wok = we && reg_ok(rd);
`ifdef REGBUS_WRITE_FIRST_EN
    if (wok) ref_regs[rd] = wdata;
    cur_exp_a = reg_ok(rs1) ? ref_regs[rs1] : '0;
    cur_exp_b = reg_ok(rs2) ? ref_regs[rs2] : '0;
    exp_lat   = wok ? 3 : 2;
    exp_post  = 1;
`else
    cur_exp_a = reg_ok(rs1) ? ref_regs[rs1] : '0;
    cur_exp_b = reg_ok(rs2) ? ref_regs[rs2] : '0;
    if (wok) ref_regs[rd] = wdata;
    exp_lat   = 2;
    exp_post  = wok ? 2 : 1;
`endif
    cur_rs1 = rs1; cur_rs2 = rs2; cur_rd = rd; cur_wdata = wdata;
    en_a_cnt = 0; en_b_cnt = 0; st_cnt = 0;

    @(posedge clk); #2;
    got = bus.req_ready;
    for (int k = 0; k < 10 && !got; k++) begin
      @(posedge clk); #2;
      got = bus.req_ready;
    end
    if (!got) check("timeout_req_ready", 32'd0, 32'd1);
    bus.req_valid = 1'b1;
    bus.req_rs1   = IDXW'(rs1);
    bus.req_rs2   = IDXW'(rs2);
    bus.req_rd    = IDXW'(rd);
    bus.req_we    = we;
    bus.req_wdata = wdata;
    bus.rsp_ready = (stall == 0);
    @(posedge clk); #2;
    bus.req_valid = 1'b0;

    got = 0; lat = 0;
    for (int k = 1; k <= 8 && !got; k++) begin
      if (k > 1) @(negedge clk); else @(negedge clk);
      if (bus.rsp_valid) begin got = 1; lat = k; end
    end
    check("read_latency", 32'(lat), 32'(exp_lat));

    held_a = bus.rsp_a;
    held_b = bus.rsp_b;
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      check("stall_valid", 32'(bus.rsp_valid), 32'd1);
      check("stall_a_stable", bus.rsp_a, held_a);
      check("stall_b_stable", bus.rsp_b, held_b);
      check("stall_req_ready", 32'(bus.req_ready), 32'd0);
    end
    if (stall > 0) begin
      @(posedge clk); #2;
      bus.rsp_ready = 1'b1;
      @(negedge clk);
    end

    hs = bus.rsp_valid && bus.rsp_ready;
    for (int k = 0; k < 8 && !hs; k++) begin
      @(negedge clk);
      hs = bus.rsp_valid && bus.rsp_ready;
    end
    if (!hs) check("timeout_handshake", 32'd0, 32'd1);
    last_a = bus.rsp_a;
    last_b = bus.rsp_b;
    @(posedge clk); #2;
    bus.rsp_ready = 1'b0;

    got = 0; post = 0;
    for (int k = 1; k <= 8 && !got; k++) begin
      @(negedge clk);
      if (bus.req_ready) begin got = 1; post = k; end
    end
    check("cycles_to_idle", 32'(post), 32'(exp_post));
    check("enable_a_cycles", 32'(en_a_cnt), reg_ok(rs1) ? 32'd1 : 32'd0);
    check("enable_b_cycles", 32'(en_b_cnt), reg_ok(rs2) ? 32'd1 : 32'd0);
    check("store_cycles", 32'(st_cnt), wok ? 32'd1 : 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < NREGS; i++) begin
      mem[i]      = 32'h1000_0000 + 32'(i);
      ref_regs[i] = 32'h1000_0000 + 32'(i);
    end
    mem[3] = 32'h0000_0001;  ref_regs[3] = 32'h0000_0001;
    mem[5] = 32'hDEAD_BEEF;  ref_regs[5] = 32'hDEAD_BEEF;
    mem[7] = 32'h1234_5678;  ref_regs[7] = 32'h1234_5678;
    cur_rs1 = 0; cur_rs2 = 0; cur_rd = 0;
    cur_wdata = '0; cur_exp_a = '0; cur_exp_b = '0;
    bus.req_valid = 1'b0; bus.req_rs1 = '0; bus.req_rs2 = '0; bus.req_rd = '0;
    bus.req_we = 1'b0; bus.req_wdata = '0; bus.rsp_ready = 1'b0;

    reset_n = 1'b0;
    #1;
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_a", bus.rsp_a, 32'd0);
    check("rst_rsp_b", bus.rsp_b, 32'd0);
    check("rst_enables", 32'(|{bus.enable_a, bus.enable_b}), 32'd0);
    check("rst_store", bus.store, 32'd0);
    check("rst_wr_data", bus.wr_data, 32'd0);
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;

    txn(5, 7, 0, 1'b0, 32'h0, 0);
    check("lit_x5", last_a, 32'hDEAD_BEEF);
    check("lit_x7", last_b, 32'h1234_5678);

    txn(0, 0, 0, 1'b0, 32'h0, 0);
    check("lit_zero_a", last_a, 32'h0);
    check("lit_zero_b", last_b, 32'h0);

    txn(3, 7, 3, 1'b1, 32'hA5A5_A5A5, 0);
`ifdef REGBUS_WRITE_FIRST_EN
    check("lit_rd_eq_rs1", last_a, 32'hA5A5_A5A5);
`else
    check("lit_rd_eq_rs1", last_a, 32'h0000_0001);
`endif
    txn(3, 31, 0, 1'b0, 32'h0, 0);
    check("lit_x3_after_write", last_a, 32'hA5A5_A5A5);
    check("lit_x31", last_b, 32'h1000_001F);

    txn(31, 6, 0, 1'b1, 32'hFFFF_FFFF, 0);
    txn(7, 7, 0, 1'b0, 32'h0, 0);
    check("lit_same_a", last_a, 32'h1234_5678);
    check("lit_same_b", last_b, 32'h1234_5678);

    txn(5, 3, 12, 1'b1, 32'h0BAD_CAFE, 10);
    check("lit_stall_a", last_a, 32'hDEAD_BEEF);
    check("lit_stall_b", last_b, 32'hA5A5_A5A5);

    // Reset in the middle of DRIVE discards a pending writeback to x9.
    @(posedge clk); #2;
    cur_rs1 = 12; cur_rs2 = 4; cur_rd = 9; cur_wdata = 32'h7777_7777;
    bus.req_valid = 1'b1; bus.req_rs1 = 5'd12; bus.req_rs2 = 5'd4;
    bus.req_rd = 5'd9; bus.req_we = 1'b1; bus.req_wdata = 32'h7777_7777;
    @(posedge clk); #2;
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("mid_drive_enable_a", bus.enable_a, onehot(12));
    #1 reset_n = 1'b0;
    #1;
    check("mid_rst_enable_a", bus.enable_a, 32'd0);
    check("mid_rst_enable_b", bus.enable_b, 32'd0);
    check("mid_rst_req_ready", 32'(bus.req_ready), 32'd1);
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("post_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("post_rst_req_ready", 32'(bus.req_ready), 32'd1);
      check("post_rst_store", bus.store, 32'd0);
    end

    txn(9, 12, 9, 1'b1, 32'h0000_9999, 0);
    check("lit_x9_untouched", last_a, 32'h1000_0009);
    txn(9, 0, 0, 1'b0, 32'h0, 0);
    check("lit_x9_written", last_a, 32'h0000_9999);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
